// File: rtl/wormhole_output_arbiter_if.sv
// Handshake bundle between the input ports, the arbiter and the downstream link.
// slave = arbiter view, master = driver view (inputs, downstream ready).
interface wormhole_output_arbiter_if #(
  parameter int IN_N      = 5,
  parameter int CHANNEL_W = 8
);
  logic [IN_N*CHANNEL_W-1:0] in_data_i;
  logic [IN_N-1:0]           in_vld_i;
  logic [IN_N-1:0]           in_req_i;
  logic [IN_N-1:0]           in_rdy_o;
  logic [CHANNEL_W-1:0]      out_data_o;
  logic                      out_vld_o;
  logic                      out_rdy_i;
  logic [IN_N-1:0]           grant_o;
  logic                      busy_o;

  modport slave (
    input  in_data_i, in_vld_i, in_req_i, out_rdy_i,
    output in_rdy_o, out_data_o, out_vld_o, grant_o, busy_o
  );

  modport master (
    output in_data_i, in_vld_i, in_req_i, out_rdy_i,
    input  in_rdy_o, out_data_o, out_vld_o, grant_o, busy_o
  );
endinterface

// File: rtl/wormhole_output_arbiter.sv
// Round-robin wormhole output arbiter: a HEAD flit wins the output, which stays locked until its TAIL.
// Optional TAIL-transfer counter on pkt_cnt_o when WH_ARB_PKT_CNT_EN is defined.
module wormhole_output_arbiter #(
  parameter int IN_N        = 5,
  parameter int FLIT_DATA_W = 6,
  parameter int FLIT_ID_W   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  wormhole_output_arbiter_if.slave arb
`ifdef WH_ARB_PKT_CNT_EN
  ,
  output logic [15:0] pkt_cnt_o
`endif
);

  localparam int CHANNEL_W = FLIT_DATA_W + FLIT_ID_W;
  localparam int PTR_W     = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam logic [FLIT_ID_W-1:0] ID_HEAD = 2'b01;
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = 2'b11;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IN_N-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CHANNEL_W-1:0] slice [IN_N];
  logic [IN_N-1:0]    cand;
  logic               owner_tail;
  logic               found;
  int unsigned        idx;

  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < IN_N; i++) begin
      slice[i] = arb.in_data_i[i*CHANNEL_W +: CHANNEL_W];
      cand[i]  = arb.in_vld_i[i] & arb.in_req_i[i] &
                 (slice[i][CHANNEL_W-1 -: FLIT_ID_W] == ID_HEAD);
    end
  end

  assign owner_tail = arb.in_vld_i[owner_q] & arb.out_rdy_i &
                      (slice[owner_q][CHANNEL_W-1 -: FLIT_ID_W] == ID_TAIL);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    found          = 1'b0;
    idx            = 0;
    arb.out_data_o = '0;
    arb.out_vld_o  = 1'b0;
    arb.in_rdy_o   = '0;
    unique case (state_q)
      S_IDLE: begin
        // Rotating search starting at ptr, wrapping modulo IN_N
        for (int unsigned off = 0; off < IN_N; off++) begin
          idx = 32'(ptr_q) + off;
          if (idx >= IN_N) idx = idx - IN_N;
          if (!found && cand[idx]) begin
            found   = 1'b1;
            owner_d = PTR_W'(idx);
          end
        end
        if (found) begin
          state_d          = S_LOCKED;
          grant_d          = '0;
          grant_d[owner_d] = 1'b1;
        end
      end
      S_LOCKED: begin
        arb.out_data_o        = slice[owner_q];
        arb.out_vld_o         = arb.in_vld_i[owner_q];
        arb.in_rdy_o[owner_q] = arb.out_rdy_i;
        if (owner_tail) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = (owner_q == PTR_W'(IN_N-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign arb.grant_o = grant_q;
  assign arb.busy_o  = (state_q == S_LOCKED);

`ifdef WH_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_q <= '0;
    end else if ((state_q == S_LOCKED) && owner_tail && (pkt_cnt_q != '1)) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed bench for wormhole_output_arbiter (IN_N=5, 6-bit payload, 2-bit id).
// Vector table for per-cycle behaviour plus hand sequences for backpressure, async reset and packet count.
module tb_wormhole_output_arbiter;

  localparam logic [1:0] NUL = 2'b00;
  localparam logic [1:0] HD  = 2'b01;
  localparam logic [1:0] BD  = 2'b10;
  localparam logic [1:0] TL  = 2'b11;

  logic clk;
  logic rst;
`ifdef WH_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  wormhole_output_arbiter_if #(.IN_N(5), .CHANNEL_W(8)) bus ();

  wormhole_output_arbiter #(
    .IN_N(5),
    .FLIT_DATA_W(6),
    .FLIT_ID_W(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .arb(bus)
`ifdef WH_ARB_PKT_CNT_EN
    ,
    .pkt_cnt_o(pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [39:0] dat;
    logic [4:0]  vld;
    logic [4:0]  req;
    logic        ordy;
    logic [7:0]  e_data;
    logic        e_vld;
    logic [4:0]  e_rdy;
    logic [4:0]  e_grant;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [39:0] pl(input int i, input logic [1:0] id, input logic [5:0] d);
    logic [39:0] r;
    r = '0;
    r[i*8 +: 8] = {id, d};
    return r;
  endfunction

  function automatic logic [7:0] fl(input logic [1:0] id, input logic [5:0] d);
    return {id, d};
  endfunction

  task automatic add(input logic r, input logic [39:0] d, input logic [4:0] v, input logic [4:0] q,
                     input logic o, input logic [7:0] ed, input logic ev, input logic [4:0] er,
                     input logic [4:0] eg, input logic eb);
    vec_t t;
    t.rst = r; t.dat = d; t.vld = v; t.req = q; t.ordy = o;
    t.e_data = ed; t.e_vld = ev; t.e_rdy = er; t.e_grant = eg; t.e_busy = eb;
    vecs.push_back(t);
  endtask

  // Vector expecting the all-zero IDLE outputs
  task automatic addi(input logic r, input logic [39:0] d, input logic [4:0] v, input logic [4:0] q);
    add(r, d, v, q, 1'b1, 8'h00, 1'b0, 5'b00000, 5'b00000, 1'b0);
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total_cnt++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else pass_cnt++;
  endtask

  task automatic step(input logic r, input logic [39:0] d, input logic [4:0] v, input logic [4:0] q,
                      input logic o);
    @(negedge clk);
    rst           = r;
    bus.in_data_i = d;
    bus.in_vld_i  = v;
    bus.in_req_i  = q;
    bus.out_rdy_i = o;
    #1;
  endtask

  task automatic check_outs(input string n, input logic [7:0] ed, input logic ev, input logic [4:0] er,
                            input logic [4:0] eg, input logic eb);
    chk({n, "_data"},  64'(bus.out_data_o), 64'(ed));
    chk({n, "_vld"},   64'(bus.out_vld_o),  64'(ev));
    chk({n, "_rdy"},   64'(bus.in_rdy_o),   64'(er));
    chk({n, "_grant"}, 64'(bus.grant_o),    64'(eg));
    chk({n, "_busy"},  64'(bus.busy_o),     64'(eb));
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_data_i = '0;
    bus.in_vld_i  = '0;
    bus.in_req_i  = '0;
    bus.out_rdy_i = 1'b0;

    // Single input 2 packet; then ptr=3 and wrap to 0
    addi(1, '0, 5'b00000, 5'b00000);
    addi(0, pl(2, HD, 6'h11), 5'b00100, 5'b00100);
    add (0, pl(2, HD, 6'h11), 5'b00100, 5'b00100, 1, fl(HD, 6'h11), 1, 5'b00100, 5'b00100, 1);
    add (0, pl(2, BD, 6'h22), 5'b00100, 5'b00100, 1, fl(BD, 6'h22), 1, 5'b00100, 5'b00100, 1);
    add (0, pl(2, TL, 6'h33), 5'b00100, 5'b00100, 1, fl(TL, 6'h33), 1, 5'b00100, 5'b00100, 1);
    addi(0, '0, 5'b00000, 5'b00000);
    addi(0, pl(0, HD, 6'h01) | pl(3, HD, 6'h03) | pl(4, HD, 6'h04), 5'b11001, 5'b11001);
    add (0, pl(0, HD, 6'h01) | pl(3, HD, 6'h03) | pl(4, HD, 6'h04), 5'b11001, 5'b11001, 1,
         fl(HD, 6'h03), 1, 5'b01000, 5'b01000, 1);
    add (0, pl(0, HD, 6'h01) | pl(3, TL, 6'h05) | pl(4, HD, 6'h04), 5'b11001, 5'b11001, 1,
         fl(TL, 6'h05), 1, 5'b01000, 5'b01000, 1);
    addi(0, pl(0, HD, 6'h01) | pl(4, HD, 6'h04), 5'b10001, 5'b10001);
    add (0, pl(0, HD, 6'h01) | pl(4, HD, 6'h04), 5'b10001, 5'b10001, 1,
         fl(HD, 6'h04), 1, 5'b10000, 5'b10000, 1);
    add (0, pl(0, HD, 6'h01) | pl(4, TL, 6'h06), 5'b10001, 5'b10001, 1,
         fl(TL, 6'h06), 1, 5'b10000, 5'b10000, 1);
    addi(0, pl(0, HD, 6'h01), 5'b00001, 5'b00001);
    add (0, pl(0, HD, 6'h01), 5'b00001, 5'b00001, 1, fl(HD, 6'h01), 1, 5'b00001, 5'b00001, 1);
    add (0, pl(0, TL, 6'h07), 5'b00001, 5'b00001, 1, fl(TL, 6'h07), 1, 5'b00001, 5'b00001, 1);
    // Non-HEAD requests and un-requested HEADs never win
    addi(0, pl(1, BD, 6'h08) | pl(2, TL, 6'h09), 5'b00110, 5'b00110);
    addi(0, pl(1, BD, 6'h08) | pl(2, TL, 6'h09), 5'b00110, 5'b00110);
    addi(0, pl(1, HD, 6'h08), 5'b00010, 5'b00000);
    addi(0, pl(1, HD, 6'h08), 5'b00000, 5'b00010);
    addi(0, pl(1, HD, 6'h08), 5'b00000, 5'b00000);

    // Inputs 0,1,3 together from ptr=0 -> order 0,1,3; then ptr=4 wins over 0
    addi(1, '0, 5'b00000, 5'b00000);
    addi(0, pl(0, HD, 6'h10) | pl(1, HD, 6'h11) | pl(3, HD, 6'h13), 5'b01011, 5'b01011);
    add (0, pl(0, HD, 6'h10) | pl(1, HD, 6'h11) | pl(3, HD, 6'h13), 5'b01011, 5'b01011, 1,
         fl(HD, 6'h10), 1, 5'b00001, 5'b00001, 1);
    add (0, pl(0, TL, 6'h20) | pl(1, HD, 6'h11) | pl(3, HD, 6'h13), 5'b01011, 5'b01011, 1,
         fl(TL, 6'h20), 1, 5'b00001, 5'b00001, 1);
    addi(0, pl(1, HD, 6'h11) | pl(3, HD, 6'h13), 5'b01010, 5'b01010);
    add (0, pl(1, HD, 6'h11) | pl(3, HD, 6'h13), 5'b01010, 5'b01010, 1,
         fl(HD, 6'h11), 1, 5'b00010, 5'b00010, 1);
    add (0, pl(1, TL, 6'h21) | pl(3, HD, 6'h13), 5'b01010, 5'b01010, 1,
         fl(TL, 6'h21), 1, 5'b00010, 5'b00010, 1);
    addi(0, pl(3, HD, 6'h13), 5'b01000, 5'b01000);
    add (0, pl(3, HD, 6'h13), 5'b01000, 5'b01000, 1, fl(HD, 6'h13), 1, 5'b01000, 5'b01000, 1);
    add (0, pl(3, TL, 6'h23), 5'b01000, 5'b01000, 1, fl(TL, 6'h23), 1, 5'b01000, 5'b01000, 1);
    addi(0, pl(0, HD, 6'h10) | pl(4, HD, 6'h14), 5'b10001, 5'b10001);
    add (0, pl(0, HD, 6'h10) | pl(4, HD, 6'h14), 5'b10001, 5'b10001, 1,
         fl(HD, 6'h14), 1, 5'b10000, 5'b10000, 1);
    add (0, pl(0, HD, 6'h10) | pl(4, TL, 6'h24), 5'b10001, 5'b10001, 1,
         fl(TL, 6'h24), 1, 5'b10000, 5'b10000, 1);
    addi(0, '0, 5'b00000, 5'b00000);

    // Owner 1 mid-packet ignores input 4's HEAD; NULL/HEAD/invalid from owner pass through
    addi(1, '0, 5'b00000, 5'b00000);
    addi(0, pl(1, HD, 6'h31), 5'b00010, 5'b00010);
    add (0, pl(1, HD, 6'h31), 5'b00010, 5'b00010, 1, fl(HD, 6'h31), 1, 5'b00010, 5'b00010, 1);
    add (0, pl(1, BD, 6'h32) | pl(4, HD, 6'h34), 5'b10010, 5'b10010, 1,
         fl(BD, 6'h32), 1, 5'b00010, 5'b00010, 1);
    add (0, pl(1, NUL, 6'h33) | pl(4, HD, 6'h34), 5'b10010, 5'b10010, 1,
         fl(NUL, 6'h33), 1, 5'b00010, 5'b00010, 1);
    add (0, pl(1, HD, 6'h35) | pl(4, HD, 6'h34), 5'b10010, 5'b10010, 1,
         fl(HD, 6'h35), 1, 5'b00010, 5'b00010, 1);
    add (0, pl(4, HD, 6'h34), 5'b10000, 5'b10000, 1, 8'h00, 0, 5'b00010, 5'b00010, 1);
    add (0, pl(1, TL, 6'h36) | pl(4, HD, 6'h34), 5'b10010, 5'b10010, 1,
         fl(TL, 6'h36), 1, 5'b00010, 5'b00010, 1);
    addi(0, pl(4, HD, 6'h34), 5'b10000, 5'b10000);
    add (0, pl(4, HD, 6'h34), 5'b10000, 5'b10000, 1, fl(HD, 6'h34), 1, 5'b10000, 5'b10000, 1);
    add (0, pl(4, TL, 6'h37), 5'b10000, 5'b10000, 1, fl(TL, 6'h37), 1, 5'b10000, 5'b10000, 1);
    addi(0, '0, 5'b00000, 5'b00000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].dat, vecs[i].vld, vecs[i].req, vecs[i].ordy);
      check_outs($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_vld, vecs[i].e_rdy,
                 vecs[i].e_grant, vecs[i].e_busy);
    end

    // Backpressure: BODY held 5 cycles, then TAIL held once
    step(1, '0, 5'b00000, 5'b00000, 1);
    step(0, pl(2, HD, 6'h01), 5'b00100, 5'b00100, 1);
    step(0, pl(2, HD, 6'h01), 5'b00100, 5'b00100, 1);
    check_outs("bp_head", fl(HD, 6'h01), 1, 5'b00100, 5'b00100, 1);
    for (int c = 0; c < 5; c++) begin
      step(0, pl(2, BD, 6'h2A), 5'b00100, 5'b00100, 0);
      check_outs($sformatf("bp_hold%0d", c), fl(BD, 6'h2A), 1, 5'b00000, 5'b00100, 1);
    end
    step(0, pl(2, BD, 6'h2A), 5'b00100, 5'b00100, 1);
    check_outs("bp_release", fl(BD, 6'h2A), 1, 5'b00100, 5'b00100, 1);
    step(0, pl(2, TL, 6'h2B), 5'b00100, 5'b00100, 0);
    step(0, pl(2, TL, 6'h2B), 5'b00100, 5'b00100, 0);
    check_outs("bp_tail_hold", fl(TL, 6'h2B), 1, 5'b00000, 5'b00100, 1);
    step(0, pl(2, TL, 6'h2B), 5'b00100, 5'b00100, 1);
    step(0, '0, 5'b00000, 5'b00000, 1);
    check_outs("bp_idle", 8'h00, 0, 5'b00000, 5'b00000, 0);

    // Async reset mid-packet with ptr=2 beforehand; afterwards ptr must be 0
    step(1, '0, 5'b00000, 5'b00000, 1);
    step(0, pl(1, HD, 6'h01), 5'b00010, 5'b00010, 1);
    step(0, pl(1, HD, 6'h01), 5'b00010, 5'b00010, 1);
    step(0, pl(1, TL, 6'h02), 5'b00010, 5'b00010, 1);
    step(0, pl(3, HD, 6'h03), 5'b01000, 5'b01000, 1);
    step(0, pl(3, HD, 6'h03), 5'b01000, 5'b01000, 1);
    check_outs("rst_head", fl(HD, 6'h03), 1, 5'b01000, 5'b01000, 1);
    step(0, pl(3, BD, 6'h04), 5'b01000, 5'b01000, 1);
    check_outs("rst_body", fl(BD, 6'h04), 1, 5'b01000, 5'b01000, 1);
    #2;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 8'h00, 0, 5'b00000, 5'b00000, 0);
    step(0, pl(0, HD, 6'h05) | pl(3, HD, 6'h06), 5'b01001, 5'b01001, 1);
    check_outs("rst_resume", 8'h00, 0, 5'b00000, 5'b00000, 0);
    step(0, pl(0, HD, 6'h05) | pl(3, HD, 6'h06), 5'b01001, 5'b01001, 1);
    check_outs("rst_ptr0", fl(HD, 6'h05), 1, 5'b00001, 5'b00001, 1);

`ifdef WH_ARB_PKT_CNT_EN
    step(1, '0, 5'b00000, 5'b00000, 1);
    chk("cnt_reset", 64'(pkt_cnt), 64'(16'd0));
    step(0, '0, 5'b00000, 5'b00000, 1);
    for (int p = 0; p < 3; p++) begin
      step(0, pl(0, HD, 6'h01), 5'b00001, 5'b00001, 1);
      step(0, pl(0, HD, 6'h01), 5'b00001, 5'b00001, 1);
      step(0, pl(0, TL, 6'h02), 5'b00001, 5'b00001, 1);
    end
    step(0, '0, 5'b00000, 5'b00000, 1);
    chk("cnt_three", 64'(pkt_cnt), 64'(16'd3));
    force dut.pkt_cnt_q = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    step(0, pl(0, HD, 6'h01), 5'b00001, 5'b00001, 1);
    step(0, pl(0, HD, 6'h01), 5'b00001, 5'b00001, 1);
    step(0, pl(0, TL, 6'h02), 5'b00001, 5'b00001, 1);
    step(0, '0, 5'b00000, 5'b00000, 1);
    chk("cnt_saturate", 64'(pkt_cnt), 64'(16'hFFFF));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wormhole_output_arbiter.md
WORMHOLE_OUTPUT_ARBITER -- requirements
Module: wormhole_output_arbiter

Interface
REQ-001 SHALL have parameter IN_N, default 5, meaning number of competing input ports; legal range 2..8.
REQ-002 SHALL have parameter FLIT_DATA_W, default 6, meaning flit payload width.
REQ-003 SHALL have parameter FLIT_ID_W, default 2, meaning flit type field width; fixed at 2. CHANNEL_W = FLIT_DATA_W + FLIT_ID_W.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port in_data_i  input  IN_N*CHANNEL_W  front flit per input; slice i = bits [(i+1)*CHANNEL_W-1 : i*CHANNEL_W]; flit id = top FLIT_ID_W bits of slice.
REQ-007 SHALL have port in_vld_i  input  IN_N  front flit valid per input.
REQ-008 SHALL have port in_req_i  input  IN_N  input i's front flit is routed to this output (from route compute).
REQ-009 SHALL have port in_rdy_o  output  IN_N  flit on input i consumed this cycle when in_vld_i[i] & in_rdy_o[i].
REQ-010 SHALL have port out_data_o  output  CHANNEL_W  forwarded flit.
REQ-011 SHALL have port out_vld_o  output  1  forwarded flit valid.
REQ-012 SHALL have port out_rdy_i  input  1  downstream ready; transfer when out_vld_o & out_rdy_i.
REQ-013 SHALL have port grant_o  output  IN_N  one-hot owner of output, all-zero when idle.
REQ-014 SHALL have port busy_o  output  1  high while state is LOCKED.

Function
REQ-015 SHALL encode flit id: 2'b00 NULL, 2'b01 HEAD, 2'b10 BODY, 2'b11 TAIL; packet = HEAD, zero or more BODY, TAIL.
REQ-016 SHALL implement two states: IDLE, LOCKED.
REQ-017 SHALL, in IDLE, treat input i as candidate iff in_vld_i[i] & in_req_i[i] & id==HEAD; non-HEAD requests are ignored.
REQ-018 SHALL, in IDLE with >=1 candidate, select the first candidate searching i = ptr, ptr+1, ... modulo IN_N, register it into grant and enter LOCKED at the next edge.
REQ-019 SHALL, in IDLE, drive out_vld_o=0, out_data_o=0, in_rdy_o=0, grant_o=0 (one-cycle arbitration latency; no flit passes in the arbitration cycle).
REQ-020 SHALL, in LOCKED with owner g, drive out_data_o=slice g, out_vld_o=in_vld_i[g], in_rdy_o[g]=out_rdy_i, all other in_rdy_o bits 0, combinationally (zero added latency per flit).
REQ-021 SHALL ignore in_req_i in LOCKED; lock released only by TAIL.
REQ-022 SHALL, on transfer of a TAIL flit from g, enter IDLE and set ptr = (g+1) mod IN_N at the same edge.
REQ-023 SHALL leave ptr unchanged at grant time; ptr changes only on TAIL transfer.
REQ-024 SHALL hold state when out_vld_o & !out_rdy_i (backpressure); out_data_o stable while in_data_i stable.
REQ-025 SHALL forward NULL or HEAD flits from owner in LOCKED unchanged without state change (no protocol checking).
REQ-026 SHALL guarantee: grant_o one-hot or zero; at most one in_rdy_o bit high.

Reset
REQ-027 SHALL on rst_i asynchronously force: state IDLE, grant 0, ptr 0, busy_o 0, out_vld_o 0, in_rdy_o 0, out_data_o 0.
REQ-028 SHALL, on reset mid-packet, drop the lock with no flush; truncated packet is upstream/downstream responsibility.
REQ-029 SHALL resume arbitration on the first edge after rst_i deasserts.

Configuration
REQ-030 SHALL, when macro WH_ARB_PKT_CNT_EN is defined, add port pkt_cnt_o  output  16  count of TAIL transfers, reset 0, +1 per TAIL transfer, saturating at 16'hFFFF.
REQ-031 SHALL, without WH_ARB_PKT_CNT_EN, omit pkt_cnt_o and its counter; all other behaviour identical.

Verification
REQ-032 SHALL cover: single input 2 HEAD/BODY/TAIL, out_rdy_i=1 -> arbitration cycle, then 3 consecutive transfers, grant_o=5'b00100, IDLE after TAIL, ptr=3.
REQ-033 SHALL cover: inputs 0,1,3 request HEAD together, ptr=0, each 2-flit packet -> served in order 0,1,3; ptr ends 4.
REQ-034 SHALL cover: owner 1 mid-packet, input 4 raises HEAD request -> ignored until input 1 TAIL; input 4 granted next.
REQ-035 SHALL cover: out_rdy_i low 5 cycles on BODY -> out_vld_o=1, out_data_o held, in_rdy_o=0, state LOCKED.
REQ-036 SHALL cover: rst_i pulse after HEAD of 4-flit packet -> outputs zero within same cycle, state IDLE, ptr 0.
REQ-037 SHALL cover (WH_ARB_PKT_CNT_EN): 3 packets -> pkt_cnt_o=3; preloaded 16'hFFFF plus one packet -> stays 16'hFFFF.
